// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one ibus read at a time and hands words to decode.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHK_EN.
module ifu_fetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            pc_branch,
    input  logic [XLEN-1:0] target_pc,
    output logic            ibus_req_valid,
    input  logic            ibus_req_ready,
    output logic [XLEN-1:0] ibus_req_addr,
    input  logic            ibus_rsp_valid,
    input  logic [XLEN-1:0] ibus_rsp_data,
`ifdef IFU_MISALIGN_CHK_EN
    output logic            inst_misalign,
`endif
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    // state  | meaning
    // S_REQ  | request presented (or about to be) on ibus
    // S_WAIT | request accepted, waiting for the response
    // S_HOLD | instruction held for decode until inst_ready
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            kill;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redir_pc;
    logic            accept;
    logic            tgt_bad;
    logic            pc_bad;
    logic            mis_hold;
    logic            raise_ok;

`ifdef IFU_MISALIGN_CHK_EN
    assign tgt      = target_pc;
    assign tgt_bad  = pc_branch && (target_pc[1:0] != 2'b00);
    assign pc_bad   = (pc[1:0] != 2'b00);
    assign mis_hold = inst_misalign;
`else
    assign tgt      = target_pc & ~XLEN'(3);
    assign tgt_bad  = 1'b0;
    assign pc_bad   = 1'b0;
    assign mis_hold = 1'b0;
`endif

    assign accept   = ibus_req_valid && ibus_req_ready;
    assign pc_inc   = pc + XLEN'(4);
    assign redir_pc = pc_branch ? tgt : pc;
    // never fetch from a misaligned pc; wait for a redirect instead
    assign raise_ok = pc_branch ? !tgt_bad : !pc_bad;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state          <= S_REQ;
            pc             <= RESET_VECTOR;
            kill           <= 1'b0;
            ibus_req_valid <= 1'b0;
            ibus_req_addr  <= '0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
`ifdef IFU_MISALIGN_CHK_EN
            inst_misalign  <= 1'b0;
`endif
        end else begin
            if (pc_branch)
                pc <= tgt;
`ifdef IFU_MISALIGN_CHK_EN
            // a trap can park us in HOLD with a request pending or a response still due
            if (state != S_REQ && accept)
                ibus_req_valid <= 1'b0;
            if (state != S_WAIT && kill && ibus_rsp_valid)
                kill <= 1'b0;
`endif
            case (state)
                S_REQ: begin
                    if (accept) begin
                        ibus_req_valid <= 1'b0;
                        state          <= S_WAIT;
                        if (pc_branch)
                            kill <= 1'b1;
                    end else if (ibus_req_valid) begin
                        if (pc_branch)
                            kill <= 1'b1;
                    end else if (!kill && raise_ok) begin
                        ibus_req_valid <= 1'b1;
                        ibus_req_addr  <= redir_pc;
                    end
                end
                S_WAIT: begin
                    if (ibus_rsp_valid && (kill || pc_branch)) begin
                        kill  <= 1'b0;
                        state <= S_REQ;
                        if (raise_ok) begin
                            ibus_req_valid <= 1'b1;
                            ibus_req_addr  <= redir_pc;
                        end
                    end else if (ibus_rsp_valid) begin
                        inst       <= ibus_rsp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end else if (pc_branch) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (pc_branch) begin
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
                        inst_misalign <= 1'b0;
`endif
                        if (!kill && raise_ok && !ibus_req_valid) begin
                            ibus_req_valid <= 1'b1;
                            ibus_req_addr  <= tgt;
                        end
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
                        inst_misalign <= 1'b0;
`endif
                        if (!mis_hold) begin
                            pc <= pc_inc;
                            if (!kill && !ibus_req_valid) begin
                                ibus_req_valid <= 1'b1;
                                ibus_req_addr  <= pc_inc;
                            end
                        end
                    end
                end
                default: state <= S_REQ;
            endcase
`ifdef IFU_MISALIGN_CHK_EN
            if (tgt_bad) begin
                state         <= S_HOLD;
                inst_valid    <= 1'b1;
                inst          <= XLEN'(32'h0000_0013);
                inst_pc       <= target_pc;
                inst_misalign <= 1'b1;
            end
`endif
        end
    end

endmodule
